serial_slave_port: RTL and testbench

//  Slave-side endpoint of the serial system bus; the counterpart of master_port.

---
 rtl/serial_slave_port.sv | 105 ++++++++++
 tb/tb_serial_slave_port.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_slave_port.sv
// serial_slave_port: serial-bus slave endpoint, deserialises address/write data, accesses local BRAM, serialises read data; define SERIAL_SLAVE_SPLIT_EN to add a split phase before read data
module serial_slave_port #(
  parameter int DATA_WIDTH = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            swdata,
  input  logic                            smode,
  input  logic                            mvalid,
  output logic                            srdata,
  output logic                            srvalid,
  output logic                            sready,
  output logic                            ssplit,
  output logic [SLAVE_MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic                            mem_wen,
  output logic                            mem_ren,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);
  localparam int AW = SLAVE_MEM_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int MW = AW > DW ? AW : DW;
  localparam int CW = $clog2(MW + 1);
  localparam logic [CW-1:0] A_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DW - 1);
  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WRITE, RMEM, RWAIT, RDATA
`ifdef SERIAL_SLAVE_SPLIT_EN
    , SPLIT
`endif
  } state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] shreg;
  logic mode;
`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam int SW = $clog2(SPLIT_LATENCY + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SPLIT_LATENCY - 1);
  logic [SW-1:0] scnt;
  assign ssplit = state == SPLIT;
`else
  assign ssplit = 1'b0;
`endif
  assign sready  = state == IDLE;
  assign mem_wen = state == WRITE;
  assign mem_ren = state == RMEM;
  assign srvalid = state == RDATA;
  assign srdata  = shreg[0];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      mode      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef SERIAL_SLAVE_SPLIT_EN
      scnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (mvalid) begin
          mem_addr <= {swdata, mem_addr[AW-1:1]};
          mode     <= smode;
          cnt      <= CW'(1);
          state    <= ADDR;
        end
        ADDR: if (mvalid) begin
          mem_addr <= {swdata, mem_addr[AW-1:1]};
          cnt      <= cnt == A_LAST ? '0 : cnt + 1'b1;
          if (cnt == A_LAST) state <= mode ? WDATA : RMEM;
        end
        WDATA: if (mvalid) begin
          mem_wdata <= {swdata, mem_wdata[DW-1:1]};
          cnt       <= cnt == D_LAST ? '0 : cnt + 1'b1;
          if (cnt == D_LAST) state <= WRITE;
        end
        WRITE: state <= IDLE;
        RMEM:  state <= RWAIT;
        RWAIT: begin
          shreg <= mem_rdata;
`ifdef SERIAL_SLAVE_SPLIT_EN
          state <= SPLIT;
`else
          state <= RDATA;
`endif
        end
`ifdef SERIAL_SLAVE_SPLIT_EN
        SPLIT: begin
          scnt <= scnt == S_LAST ? '0 : scnt + 1'b1;
          if (scnt == S_LAST) state <= RDATA;
        end
`endif
        RDATA: begin
          shreg <= {1'b0, shreg[DW-1:1]};
          cnt   <= cnt == D_LAST ? '0 : cnt + 1'b1;
          if (cnt == D_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: directed transactions against a cycle-scheduled expectation model of the serial slave
module tb_serial_slave_port;
  localparam int AW = 12, DW = 8, N = 4096;
`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam int L = 4;
`else
  localparam int L = 0;
`endif
  logic clk = 0, rstn = 0, swdata = 0, smode = 0, mvalid = 0;
  logic srdata, srvalid, sready, ssplit, mem_wen, mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  int cyc = 0, errors = 0, checks = 0;
  bit e_busy[N], e_wen[N], e_ren[N], e_srv[N], e_srd[N], e_split[N];
  logic [AW-1:0] e_addr[N];
  logic [DW-1:0] e_wdata[N], bram[N], ref_mem[N];
  logic [DW-1:0] rx = 0, w_data;
  logic [AW-1:0] w_addr;
  int rx_n = 0, wen_n = 0, split_n = 0, first_srv = 0, last_addr_cyc = 0;
  bit prev_srv = 0;

  serial_slave_port #(.DATA_WIDTH(DW), .SLAVE_MEM_ADDR_WIDTH(AW), .SPLIT_LATENCY(4)) dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .srvalid(srvalid), .sready(sready), .ssplit(ssplit),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_wen) bram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= bram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) if (cyc >= 1 && cyc < N) begin
    check("sready", sready, !e_busy[cyc]);
    check("mem_wen", mem_wen, e_wen[cyc]);
    check("mem_ren", mem_ren, e_ren[cyc]);
    check("srvalid", srvalid, e_srv[cyc]);
    check("ssplit", ssplit, e_split[cyc]);
    if (e_wen[cyc] || e_ren[cyc]) check("mem_addr", mem_addr, e_addr[cyc]);
    if (e_wen[cyc]) check("mem_wdata", mem_wdata, e_wdata[cyc]);
    if (e_srv[cyc]) check("srdata", srdata, e_srd[cyc]);
  end

  always @(negedge clk) begin
    if (srvalid === 1'b1) begin
      rx = {srdata, rx[DW-1:1]};
      rx_n++;
      if (!prev_srv) first_srv = cyc;
    end
    prev_srv = srvalid === 1'b1;
    if (mem_wen === 1'b1) begin
      wen_n++;
      w_addr = mem_addr;
      w_data = mem_wdata;
    end
    if (ssplit === 1'b1) split_n++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < N; i++) begin
      e_busy[i] = 0; e_wen[i] = 0; e_ren[i] = 0; e_srv[i] = 0; e_srd[i] = 0; e_split[i] = 0;
    end
  endtask

  // Expected activity is laid out on absolute cycle numbers from the transaction's last serial bit.
  task automatic transact(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit gaps, input bit noise, input int abort);
    int s, t, e, n;
    logic [AW+DW-1:0] v;
    v = {d, a};
    n = wr ? AW + DW : AW;
    s = -1;
    t = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        mvalid = 0; swdata = 1'($urandom); smode = 1'($urandom);
        if (s >= 0) e_busy[cyc+1] = 1;
        step;
      end
      mvalid = 1; swdata = v[i]; smode = i == 0 ? wr : 1'($urandom);
      if (i == 0) s = cyc;
      if (i == AW - 1) last_addr_cyc = cyc;
      t = cyc;
      e_busy[cyc+1] = 1;
      step;
    end
    mvalid = 0;
    if (wr) begin
      e = t + 1;
      e_wen[e] = 1; e_addr[e] = a; e_wdata[e] = d;
      ref_mem[a] = d;
    end else begin
      e_ren[t+1] = 1; e_addr[t+1] = a;
      for (int i = 0; i < L; i++) e_split[t+3+i] = 1;
      for (int i = 0; i < DW; i++) begin
        e_srv[t+3+L+i] = 1;
        e_srd[t+3+L+i] = ref_mem[a][i];
      end
      e = t + 2 + L + DW;
    end
    for (int c = t + 1; c <= e; c++) e_busy[c] = 1;
    while (cyc <= e) begin
      if (abort >= 0 && cyc == t + 3 + L + abort) begin
        mvalid = 0; rstn = 0;
        clear_from(cyc + 1);
        step;
        rstn = 1;
        return;
      end
      mvalid = noise ? 1'($urandom) : 1'b0; swdata = 1'($urandom); smode = 1'($urandom);
      step;
    end
    mvalid = 0;
  endtask

  initial begin
    int w0, r0, s0;
    rstn = 0;
    repeat (3) step;
    rstn = 1;
    check("reset_sready", sready, 1);
    check("reset_srvalid", srvalid, 0);
    w0 = wen_n;
    transact(1, 12'h123, 8'hA5, 0, 0, -1);
    check("wr_pulses", wen_n - w0, 1);
    check("wr_addr", w_addr, 12'h123);
    check("wr_data", w_data, 8'hA5);
    check("wr_sready_back", sready, 1);
    r0 = rx_n; s0 = split_n;
    transact(0, 12'h123, 8'h00, 0, 1, -1);
    check("rd_data", rx, 8'hA5);
    check("rd_bits", rx_n - r0, 8);
    check("rd_latency", first_srv - last_addr_cyc, 3 + L);
    check("rd_split_cycles", split_n - s0, L);
    w0 = wen_n;
    transact(1, 12'h123, 8'hA5, 1, 0, -1);
    check("gap_pulses", wen_n - w0, 1);
    check("gap_addr", w_addr, 12'h123);
    check("gap_data", w_data, 8'hA5);
    w0 = wen_n; r0 = rx_n;
    transact(0, 12'h123, 8'h00, 0, 1, 4);
    check("abort_srvalid", srvalid, 0);
    check("abort_sready", sready, 1);
    repeat (20) step;
    check("abort_bits", rx_n - r0, 5);
    check("abort_no_wen", wen_n - w0, 0);
    transact(1, 12'h7FF, 8'h3C, 0, 0, -1);
    transact(0, 12'h7FF, 8'h00, 0, 0, -1);
    check("b2b_data", rx, 8'h3C);
    transact(1, 12'h000, 8'h81, 1, 0, -1);
    transact(0, 12'h000, 8'h00, 1, 1, -1);
    check("gap_rd_data", rx, 8'h81);
    repeat (5) step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
